// File: rtl/shift_iter_unit.sv
// Iterative shifter: breaks a 0..WIDTH-1 shift into BIG_STEP-bit steps, then 1-bit steps,
// one step per clock, and returns the result with a one-cycle done pulse.
module shift_iter_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BIG_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic                       arith,
  input  logic [WIDTH-1:0]           operand,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_rem_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_arith;
  logic             w_arith_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;

  logic             w_big;
  logic             w_fill;
  logic [WIDTH-1:0] w_work_step;
  logic [SHW-1:0]   w_rem_step;

  // One shift step; the fill bit is the current sign, which a right-arith step never changes
  always_comb begin
    w_big  = (r_rem >= SHW'(BIG_STEP));
    w_fill = r_dir & r_arith & r_work[WIDTH-1];
    if (r_dir) begin
      if (w_big) w_work_step = {{BIG_STEP{w_fill}}, r_work[WIDTH-1:BIG_STEP]};
      else       w_work_step = {w_fill, r_work[WIDTH-1:1]};
    end else begin
      if (w_big) w_work_step = {r_work[WIDTH-1-BIG_STEP:0], {BIG_STEP{1'b0}}};
      else       w_work_step = {r_work[WIDTH-2:0], 1'b0};
    end
    w_rem_step = r_rem - (w_big ? SHW'(BIG_STEP) : SHW'(1));
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_rem_nxt    = r_rem;
    w_dir_nxt    = r_dir;
    w_arith_nxt  = r_arith;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_nxt  = operand;
          w_rem_nxt   = shamt;
          w_dir_nxt   = dir;
          w_arith_nxt = arith;
          if (shamt == '0) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = operand;
          end else begin
            w_state_nxt  = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_work_step;
        w_rem_nxt  = w_rem_step;
        if (w_rem_step == '0) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = w_work_step;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_arith  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_rem    <= w_rem_nxt;
      r_dir    <= w_dir_nxt;
      r_arith  <= w_arith_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Self-checking bench for shift_iter_unit: latency/result model plus directed and random stimulus.
module tb_shift_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic        arith;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests;
  int fails;

  shift_iter_unit #(.WIDTH(32), .BIG_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .arith(arith),
    .operand(operand), .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] sh,
                                            input logic d, input logic a);
    if (!d)     return op << sh;
    else if (a) return 32'($signed(op) >>> sh);
    else        return op >> sh;
  endfunction

  // Model: an accepted op keeps the unit busy for (shamt/4 + shamt%4) shift cycles plus one done cycle
  int          m_left;
  logic [31:0] m_pending;
  logic [31:0] m_result;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_result = 32'h0;
    end else if (m_left == 0) begin
      if (start === 1'b1) begin
        m_pending = ref_shift(operand, shamt, dir, arith);
        m_left    = int'(shamt) / 4 + int'(shamt) % 4 + 1;
        if (m_left == 1) m_result = m_pending;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) m_result = m_pending;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy",   32'(busy),   32'(m_left != 0));
      chk("done",   32'(done),   32'(m_left == 1));
      chk("result", result,      m_result);
    end
  end

  // Start an op now, optionally re-pulse start with junk at cycle inj, return done-cycle index and result
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input logic d,
                        input logic a, input int inj, output int cyc, output logic [31:0] res);
    @(negedge clk);
    operand = op; shamt = sh; dir = d; arith = a; start = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == inj) begin
        start = 1'b1; operand = $urandom; shamt = 5'($urandom); dir = ~d; arith = ~a;
      end else if (i == inj + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        cyc = i;
        res = result;
        break;
      end
    end
    start = 1'b0;
    if (cyc == 0) begin
      chk("timeout", 32'(0), 32'(1));
      res = 32'hx;
    end
  endtask

  int          cyc;
  logic [31:0] res;
  logic [31:0] held;
  logic        seen;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; arith = 1'b0; operand = '0; shamt = '0;
    #1;
    chk("reset_busy",   32'(busy), 32'h0);
    chk("reset_done",   32'(done), 32'h0);
    chk("reset_result", result,    32'h0);

    chk("model_left",  ref_shift(32'h0000_00F1, 5'd7, 1'b0, 1'b0), 32'h0000_7880);
    chk("model_arith", ref_shift(32'h8000_0010, 5'd9, 1'b1, 1'b1), 32'hFFC0_0000);
    chk("model_lsr",   ref_shift(32'h8000_0010, 5'd9, 1'b1, 1'b0), 32'h0040_0000);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h0000_00F1, 5'd7, 1'b0, 1'b0, 0, cyc, res);
    chk("left_res", res, 32'h0000_7880);
    chk("left_lat", 32'(cyc), 32'd5);

    run_op(32'h8000_0010, 5'd9, 1'b1, 1'b1, 0, cyc, res);
    chk("asr_res", res, 32'hFFC0_0000);
    chk("asr_lat", 32'(cyc), 32'd4);

    run_op(32'h8000_0010, 5'd9, 1'b1, 1'b0, 0, cyc, res);
    chk("lsr_res", res, 32'h0040_0000);

    run_op(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 0, cyc, res);
    chk("zero_res", res, 32'hDEAD_BEEF);
    chk("zero_lat", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("zero_busy_after", 32'(busy), 32'h0);

    run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 4, cyc, res);
    chk("max_res", res, 32'h0000_0001);
    chk("max_lat", 32'(cyc), 32'd11);

    // Back-to-back: start held from the DONE cycle through the following IDLE edge
    held = res;
    start = 1'b1; operand = 32'h1111_1111; shamt = 5'd4; dir = 1'b1; arith = 1'b1;
    @(negedge clk);
    operand = 32'h0000_00F0; shamt = 5'd4; dir = 1'b0; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy",   32'(busy), 32'h1);
    chk("b2b_held",   result,    held);
    cyc = 1;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_lat", 32'(cyc), 32'd2);
    chk("b2b_res", result,   32'h0000_0F00);

    // Random traffic, including starts while busy and input churn mid-operation
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(3, 0) == 0);
      operand = $urandom;
      case ($urandom_range(7, 0))
        0:       shamt = 5'd0;
        1:       shamt = 5'd31;
        default: shamt = 5'($urandom);
      endcase
      dir   = 1'($urandom);
      arith = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-shift aborts with no done pulse
    run_op(32'h1234_5678, 5'd1, 1'b0, 1'b0, 0, cyc, res);
    @(negedge clk);
    operand = 32'hFFFF_FFFF; shamt = 5'd31; dir = 1'b1; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_result", result,    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("rst_no_done", 32'(seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_iter_unit.md
Name: shift_iter_unit

Overview:
Multi-cycle iterative shifter for the KGP-RISC execute stage. It feeds and sequences the fixed-amount shift stages: a variable shift of 0..31 is broken into steps of 4 bits, then steps of 1 bit, one step per clock. It accepts a shift request from the ALU control, holds the operand in an internal working register, and returns the final result with a one-cycle done pulse. Supported operations are logical left, logical right and arithmetic right.

Parameters:
WIDTH, 32, operand/result width in bits; fixed at 32 for this core.
BIG_STEP, 4, coarse step size in bits; must be a power of two less than WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only in IDLE.
dir  input  1  0 = left, 1 = right.
arith  input  1  1 = arithmetic right (sign fill); ignored when dir = 0.
operand  input  32  value to shift; latched on accepted start.
shamt  input  5  shift amount 0..31; latched on accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  single-cycle pulse; result is valid in this cycle.
result  output  32  final shifted value; held stable until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; result = 0.
  - Working register, remaining count, dir and arith latches all = 0.
  - Reset asserted mid-operation aborts the shift immediately. No done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start = 1 at a rising edge: latch operand into work, shamt into rem, and latch dir and arith.
  - Next state is SHIFT if shamt != 0, else DONE.
  - start = 0: stay in IDLE.
- SHIFT, one step per edge:
  - If rem >= BIG_STEP: shift work by BIG_STEP; rem -= BIG_STEP.
  - Else: shift work by 1; rem -= 1.
  - When the updated rem == 0: next state is DONE, and result is loaded with the updated work on the same edge.
- Shift rules, for both step sizes:
  - Left: zero fill at the LSBs.
  - Right logical: zero fill at the MSBs.
  - Right arithmetic: fill with the latched work[31] (the sign at step time). The sign is invariant across steps.
- DONE:
  - done = 1 for exactly one cycle; busy = 1.
  - Next state is always IDLE.
  - For shamt = 0, result = operand unchanged.
- Latency:
  - Number of SHIFT cycles N = floor(shamt/4) + (shamt mod 4); maximum N = 7 + 3 = 10 (shamt = 31).
  - done is high in the cycle after the (N+1)-th rising edge counted from, and including, the start edge.
  - shamt = 0 gives done in the cycle right after the start edge.
- start while busy (SHIFT or DONE) is ignored. It is not queued, and inputs are not relatched.
- Back-to-back: the earliest next start is accepted on the edge where the state is IDLE, i.e. one edge after DONE.
- Changes on operand, shamt, dir or arith after acceptance have no effect on the operation in progress.
- result changes only on the SHIFT→DONE or IDLE→DONE transition, never in IDLE.

Test Plan:
- Reset: hold rst_n = 0 mid-SHIFT (shamt = 31 running), release → busy = 0, done = 0, result = 0, no later done pulse.
- Left: operand = 0x0000_00F1, shamt = 7, dir = 0 → 4 SHIFT cycles, then done with result = 0x0000_7880.
- Arith right: operand = 0x8000_0010, shamt = 9, dir = 1, arith = 1 → 3 SHIFT cycles, done with result = 0xFFC0_0000. The same stimulus with arith = 0 gives 0x0040_0000.
- Zero amount: operand = 0xDEAD_BEEF, shamt = 0 → done in the cycle after start, result = 0xDEAD_BEEF, busy high for exactly 1 cycle.
- Max amount: operand = 0xFFFF_FFFF, shamt = 31, dir = 1, arith = 0 → 10 SHIFT cycles, result = 0x0000_0001. Re-pulsing start with a new operand during SHIFT changes nothing.
- Back-to-back: second start asserted in the DONE cycle is ignored. Asserting it again in the following IDLE cycle is accepted, and the earlier result stays held until the new done.
